i2s_adc_receiver: RTL and testbench
===================================

I2S_ADC_RECEIVER -- requirements
Module: i2s_adc_receiver

Interface
REQ-001 SHALL have parameter LEADING_BITS, default 1, meaning the number of dummy BCLK bits after each LRCK edge and before the sample MSB.
REQ-002 SHALL have parameter DATA_BITS, default 16, meaning the sample width per channel.
REQ-003 SHALL have parameter TRAILING_BITS, default 15, meaning the number of dummy BCLK bits after the sample LSB within one LRCK half-period.
REQ-004 SHALL have port clk, input, 1 bit: system clock, the only clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port codec_aud_bclk_i, input, 1 bit: codec bit clock, asynchronous to clk.
REQ-007 SHALL have port codec_aud_adclrck_i, input, 1 bit: ADC word select; 1 = left, 0 = right; asynchronous.
REQ-008 SHALL have port codec_aud_adcdat_i, input, 1 bit: ADC serial data, MSB first, asynchronous.
REQ-009 SHALL have port i2s_enable_i, input, 1 bit: receive enable.
REQ-010 SHALL have port i2s_ack_i, input, 1 bit: consumer acknowledge of the held sample pair.
REQ-011 SHALL have port i2s_sample_data_L_o, output, DATA_BITS bits: last complete left sample.
REQ-012 SHALL have port i2s_sample_data_R_o, output, DATA_BITS bits: last complete right sample.
REQ-013 SHALL have port i2s_valid_o, output, 1 bit: sample pair available, held until acknowledged.
REQ-014 SHALL have port i2s_overrun_o, output, 1 bit: sticky flag, set when a pair is overwritten while unacknowledged.
REQ-015 SHALL have port i2s_frame_err_o, output, 1 bit: sticky flag, set on a short LRCK half-period.

Function
REQ-016 SHALL pass bclk, adclrck and adcdat each through a 2-flop synchronizer, followed by one further register per signal for edge detection.
REQ-017 SHALL generate bclk_rise as a one-clk pulse on each synchronized BCLK 0->1 transition; all capture logic SHALL act only in cycles where bclk_rise=1.
REQ-018 SHALL require each BCLK half-period to be >= 3 clk periods; behaviour outside this constraint is unspecified.
REQ-019 SHALL, in each bclk_rise cycle, sample the synchronized LRCK and DATA values of that same cycle.
REQ-020 SHALL treat a bclk_rise whose LRCK differs from the LRCK at the previous bclk_rise as bit tick 0 and increment the tick counter on each later bclk_rise; the counter SHALL saturate at LEADING_BITS+DATA_BITS+TRAILING_BITS-1.
REQ-021 SHALL shift DATA into the active channel shift register MSB first at ticks LEADING_BITS .. LEADING_BITS+DATA_BITS-1 and ignore all other ticks.
REQ-022 SHALL implement FSM states WAIT_SYNC, RX_LEFT and RX_RIGHT; reset and i2s_enable_i=0 SHALL force WAIT_SYNC.
REQ-023 SHALL, in WAIT_SYNC with enable=1, move to RX_LEFT on an LRCK 0->1 change; data in a partial half already in progress SHALL be discarded.
REQ-024 SHALL move RX_LEFT->RX_RIGHT on an LRCK 1->0 change and RX_RIGHT->RX_LEFT on an LRCK 0->1 change.
REQ-025 SHALL, if LRCK changes in RX_LEFT or RX_RIGHT before tick LEADING_BITS+DATA_BITS-1 is captured, set i2s_frame_err_o, discard the partial pair, go to WAIT_SYNC and suppress any valid for that pair.
REQ-026 SHALL, when RX_RIGHT captures tick LEADING_BITS+DATA_BITS-1 after a complete left word, load both output registers and set i2s_valid_o at the next clk edge; latency from the capturing bclk_rise cycle is 1 clk.
REQ-027 SHALL clear i2s_valid_o on the clk edge following a cycle with i2s_ack_i=1 and no simultaneous load.
REQ-028 SHALL, on a load while i2s_valid_o=1 and i2s_ack_i=0, overwrite the output data, keep valid=1 and set i2s_overrun_o.
REQ-029 SHALL, on a load coinciding with i2s_ack_i=1, load the new pair, keep valid=1 and leave i2s_overrun_o unchanged.
REQ-030 SHALL keep the output data stable while i2s_valid_o=1, except on a load.
REQ-031 SHALL clear the sticky flags only by reset.

Reset
REQ-032 SHALL, on a clk edge with rst=1, set every output, shift register, counter and synchronizer flop to 0 and the FSM to WAIT_SYNC, including when reset occurs mid-word.
REQ-033 SHALL ignore i2s_ack_i, i2s_enable_i and all codec inputs while rst=1.

Verification
REQ-034 SHALL verify a basic frame with defaults: enable=1, frame L=16'hA5C3 then R=16'h3C5A -> valid=1 one clk after the R LSB bclk_rise, L_o=A5C3, R_o=3C5A, both flags 0.
REQ-035 SHALL verify overrun: two frames (1234/5678 then 9ABC/DEF0) with no ack -> L_o=9ABC, R_o=DEF0, valid=1, overrun=1.
REQ-036 SHALL verify acknowledge collision: ack asserted in the same cycle as the second load -> valid stays 1, overrun=0, second pair on the outputs.
REQ-037 SHALL verify a short half: a left half of only 8 BCLKs -> frame_err=1, no valid; the next full frame 0F0F/F0F0 is received correctly.
REQ-038 SHALL verify a mid-stream start: enable raised at left tick 5 -> that partial frame is discarded and the first valid carries the next full frame.
REQ-039 SHALL verify reset mid-word: rst pulsed at right tick 9 -> all outputs 0, FSM in WAIT_SYNC; the following full frame is received intact.

Source files
------------

// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver.
// Oversamples the codec BCLK/LRCK/DATA lines in the clk domain and deserializes
// one left/right sample pair per LRCK frame. The pair is handed to a consumer
// through a valid/ack hold register, with sticky overrun and framing-error flags.
module i2s_adc_receiver #(
    parameter int LEADING_BITS  = 1,
    parameter int DATA_BITS     = 16,
    parameter int TRAILING_BITS = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 codec_aud_bclk_i,
    input  logic                 codec_aud_adclrck_i,
    input  logic                 codec_aud_adcdat_i,
    input  logic                 i2s_enable_i,
    input  logic                 i2s_ack_i,
    output logic [DATA_BITS-1:0] i2s_sample_data_L_o,
    output logic [DATA_BITS-1:0] i2s_sample_data_R_o,
    output logic                 i2s_valid_o,
    output logic                 i2s_overrun_o,
    output logic                 i2s_frame_err_o
);

    localparam int TOTAL_TICKS = LEADING_BITS + DATA_BITS + TRAILING_BITS;
    localparam int TW          = (TOTAL_TICKS > 1) ? $clog2(TOTAL_TICKS) : 1;

    localparam logic [TW-1:0] TICK_FIRST = TW'(LEADING_BITS);
    localparam logic [TW-1:0] TICK_LAST  = TW'(LEADING_BITS + DATA_BITS - 1);
    localparam logic [TW-1:0] TICK_MAX   = TW'(TOTAL_TICKS - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        RX_LEFT,
        RX_RIGHT
    } state_t;

    // Bits [1:0] are the two synchronizer flops, bit [2] is the edge-detect stage.
    logic [2:0] bclk_pipe;
    logic [2:0] lrck_pipe;
    logic [2:0] dat_pipe;

    logic          bclk_rise;
    logic          lrck_smp;
    logic          dat_smp;
    logic          lrck_prev;
    logic          lrck_change;
    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_cur;
    logic          in_window;
    logic          half_done;
    logic          load;

    state_t                 state;
    logic [DATA_BITS-1:0]   shift_l;
    // The last right bit goes straight into the output register, so only
    // DATA_BITS-1 right bits ever need to be held here.
    logic [DATA_BITS-2:0]   shift_r;
    logic [DATA_BITS-1:0]   right_word;

    // Bring the asynchronous codec lines into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_pipe <= '0;
            lrck_pipe <= '0;
            dat_pipe  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop take its pre-edge
            // input, so each chain advances exactly one stage per clk.
            bclk_pipe <= {bclk_pipe[1:0], codec_aud_bclk_i};
            lrck_pipe <= {lrck_pipe[1:0], codec_aud_adclrck_i};
            dat_pipe  <= {dat_pipe[1:0], codec_aud_adcdat_i};
        end
    end

    // LRCK and DATA are taken from the edge-detect stage. They settled on the
    // preceding BCLK fall, which is at least three clk periods earlier.
    assign bclk_rise   = bclk_pipe[1] & ~bclk_pipe[2];
    assign lrck_smp    = lrck_pipe[2];
    assign dat_smp     = dat_pipe[2];
    assign lrck_change = (lrck_smp != lrck_prev);

    // Work out the tick number of the current bit: 0 on an LRCK change, otherwise a saturating +1.
    always_comb begin
        // NOTE: giving the signal a default first means every path drives it,
        // so no latch is inferred.
        tick_cur = tick_q;
        if (lrck_change) begin
            tick_cur = '0;
        end else if (tick_q != TICK_MAX) begin
            tick_cur = tick_q + 1'b1;
        end
    end

    assign in_window  = (tick_cur >= TICK_FIRST) && (tick_cur <= TICK_LAST);
    // When LRCK changes, tick_q still holds the final tick of the half that just ended.
    assign half_done  = (tick_q >= TICK_LAST);
    assign right_word = {shift_r, dat_smp};
    assign load       = i2s_enable_i && bclk_rise && (state == RX_RIGHT)
                        && !lrck_change && (tick_cur == TICK_LAST);

    // On every BCLK rise, record LRCK and advance the bit tick counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lrck_prev <= 1'b0;
            tick_q    <= '0;
        end else if (bclk_rise) begin
            lrck_prev <= lrck_smp;
            tick_q    <= tick_cur;
        end
    end

    // Frame FSM: deserializes both channels, then manages the output hold register and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= WAIT_SYNC;
            shift_l             <= '0;
            shift_r             <= '0;
            i2s_sample_data_L_o <= '0;
            i2s_sample_data_R_o <= '0;
            i2s_valid_o         <= 1'b0;
            i2s_overrun_o       <= 1'b0;
            i2s_frame_err_o     <= 1'b0;
        end else begin
            if (!i2s_enable_i) begin
                state <= WAIT_SYNC;
            end else if (bclk_rise) begin
                unique case (state)
                    WAIT_SYNC: begin
                        // Only a left-channel start realigns; any partial half is dropped.
                        if (lrck_change && lrck_smp) begin
                            state <= RX_LEFT;
                        end
                    end
                    RX_LEFT: begin
                        if (lrck_change) begin
                            if (half_done) begin
                                state <= RX_RIGHT;
                            end else begin
                                state           <= WAIT_SYNC;
                                i2s_frame_err_o <= 1'b1;
                            end
                        end else if (in_window) begin
                            shift_l <= {shift_l[DATA_BITS-2:0], dat_smp};
                        end
                    end
                    RX_RIGHT: begin
                        if (lrck_change) begin
                            if (half_done) begin
                                state <= RX_LEFT;
                            end else begin
                                state           <= WAIT_SYNC;
                                i2s_frame_err_o <= 1'b1;
                            end
                        end else if (in_window) begin
                            shift_r <= right_word[DATA_BITS-2:0];
                        end
                    end
                    default: state <= WAIT_SYNC;
                endcase
            end

            // A load takes priority over an acknowledge arriving in the same cycle.
            if (load) begin
                i2s_sample_data_L_o <= shift_l;
                i2s_sample_data_R_o <= right_word;
                i2s_valid_o         <= 1'b1;
                if (i2s_valid_o && !i2s_ack_i) begin
                    i2s_overrun_o <= 1'b1;
                end
            end else if (i2s_ack_i) begin
                i2s_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Self-checking bench for i2s_adc_receiver. It drives I2S frames bit by bit
// and compares the outputs with a half-period-level reference model.
module tb_i2s_adc_receiver;

    localparam int LB   = 1;
    localparam int DB   = 16;
    localparam int TB   = 15;
    localparam int HALF = LB + DB + TB;

    localparam int HK_NONE    = 0;
    localparam int HK_LATENCY = 1;
    localparam int HK_ACK     = 2;
    localparam int HK_ENABLE  = 3;
    localparam int HK_RESET   = 4;

    logic          clk;
    logic          rst;
    logic          bclk;
    logic          lrck;
    logic          dat;
    logic          enable;
    logic          ack;
    logic [DB-1:0] l_o;
    logic [DB-1:0] r_o;
    logic          valid;
    logic          ovr;
    logic          ferr;

    int errors = 0;
    int checks = 0;

    // Reference model state, tracked one LRCK half-period at a time.
    logic          m_valid;
    logic          m_ovr;
    logic          m_ferr;
    logic          m_locked;
    logic [DB-1:0] m_L;
    logic [DB-1:0] m_R;
    logic [DB-1:0] m_left;
    int            m_prev_len;

    wire [2*DB+2:0] obs = {valid, ovr, ferr, l_o, r_o};

    i2s_adc_receiver #(
        .LEADING_BITS (LB),
        .DATA_BITS    (DB),
        .TRAILING_BITS(TB)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .codec_aud_bclk_i   (bclk),
        .codec_aud_adclrck_i(lrck),
        .codec_aud_adcdat_i (dat),
        .i2s_enable_i       (enable),
        .i2s_ack_i          (ack),
        .i2s_sample_data_L_o(l_o),
        .i2s_sample_data_R_o(r_o),
        .i2s_valid_o        (valid),
        .i2s_overrun_o      (ovr),
        .i2s_frame_err_o    (ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*DB+2:0] model_vec();
        return {m_valid, m_ovr, m_ferr, m_L, m_R};
    endfunction

    task automatic model_reset();
        m_valid    = 1'b0;
        m_ovr      = 1'b0;
        m_ferr     = 1'b0;
        m_locked   = 1'b0;
        m_L        = '0;
        m_R        = '0;
        m_left     = '0;
        m_prev_len = 0;
    endtask

    // Applies the receive rules to one complete half-period: its channel, its word,
    // its length in BCLKs, the enable level when it began, and whether an ack was
    // present in the cycle the pair would load.
    task automatic model_half(input logic lr, input logic [DB-1:0] w, input int nbits,
                              input logic en, input logic ack_at_load);
        logic active;
        active = 1'b0;
        if (!en) begin
            m_locked = 1'b0;
        end else if (m_locked && m_prev_len < LB + DB) begin
            m_ferr   = 1'b1;
            m_locked = 1'b0;
        end else if (m_locked || lr) begin
            m_locked = 1'b1;
            active   = 1'b1;
        end
        if (active) begin
            if (lr) begin
                m_left = w;
            end else if (nbits >= LB + DB) begin
                if (m_valid && !ack_at_load) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_L     = m_left;
                m_R     = w;
            end
        end
        m_prev_len = nbits;
    endtask

    // Drives one BCLK period (4 clk low, 4 clk high). LRCK and DATA change on the
    // falling edge. An optional action runs after the rising edge.
    task automatic bclk_bit(input logic lr, input logic d, input int hook);
        @(posedge clk);
        #2;
        bclk = 1'b0;
        lrck = lr;
        dat  = d;
        repeat (4) @(posedge clk);
        #2 bclk = 1'b1;
        case (hook)
            HK_LATENCY: begin
                repeat (2) @(posedge clk);
                #1;
                checks++;
                if (valid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_early: valid=%b two clk after LSB rise, required 0", valid);
                end
                @(posedge clk);
                #1;
                checks++;
                if (valid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_load: valid=%b three clk after LSB rise, required 1", valid);
                end
            end
            HK_ACK: begin
                repeat (2) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
            end
            HK_ENABLE: begin
                @(posedge clk);
                #1 enable = 1'b1;
                repeat (2) @(posedge clk);
                #1;
            end
            HK_RESET: begin
                @(posedge clk);
                #1;
                rst = 1'b1;
                ack = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                ack = 1'b0;
                checks++;
                if (obs !== '0) begin
                    errors++;
                    $display("FAIL reset_midword_zero: outputs=%h, required 0", obs);
                end
                @(posedge clk);
                #1;
            end
            default: begin
                repeat (3) @(posedge clk);
                #1;
            end
        endcase
    endtask

    task automatic send_half(input logic lr, input logic [DB-1:0] w, input int nbits,
                             input int hook_tick, input int hook);
        for (int t = 0; t < nbits; t++) begin
            logic b;
            if (t >= LB && t < LB + DB) b = w[DB-1-(t-LB)];
            else b = 1'($urandom_range(0, 1));
            bclk_bit(lr, b, (t == hook_tick) ? hook : HK_NONE);
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] lw, input logic [DB-1:0] rw, input int rhook);
        logic en;
        en = enable;
        send_half(1'b1, lw, HALF, -1, HK_NONE);
        model_half(1'b1, lw, HALF, en, 1'b0);
        en = enable;
        send_half(1'b0, rw, HALF, LB + DB - 1, rhook);
        model_half(1'b0, rw, HALF, en, rhook == HK_ACK);
    endtask

    // A full right half, so the next left half begins with a real LRCK 0->1 edge.
    task automatic lead_in();
        logic [DB-1:0] w;
        w = DB'($urandom);
        send_half(1'b0, w, HALF, -1, HK_NONE);
        model_half(1'b0, w, HALF, enable, 1'b0);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic do_reset(input logic en);
        rst    = 1'b1;
        ack    = 1'b0;
        bclk   = 1'b0;
        lrck   = 1'b0;
        dat    = 1'b0;
        enable = en;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b1;
        ack    = 1'b1;
        bclk   = 1'b1;
        lrck   = 1'b1;
        dat    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h, required 0", obs);
        end
        bclk = 1'b0;
        lrck = 1'b0;
        dat  = 1'b0;
        ack  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obs !== model_vec()) begin
            errors++;
            $display("FAIL reset_release: outputs=%h, required %h", obs, model_vec());
        end
    endtask

    task automatic test_basic_frame();
        do_reset(1'b1);
        lead_in();
        send_frame(16'hA5C3, 16'h3C5A, HK_LATENCY);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 16'hA5C3, 16'h3C5A}) begin
            errors++;
            $display("FAIL basic_frame: outputs=%h, required %h", obs,
                     {1'b1, 1'b0, 1'b0, 16'hA5C3, 16'h3C5A});
        end
        checks++;
        if (obs !== model_vec()) begin
            errors++;
            $display("FAIL basic_model: outputs=%h, required %h", obs, model_vec());
        end
    endtask

    task automatic test_overrun();
        do_reset(1'b1);
        lead_in();
        send_frame(16'h1234, 16'h5678, HK_NONE);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678}) begin
            errors++;
            $display("FAIL overrun_first: outputs=%h, required %h", obs,
                     {1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678});
        end
        send_frame(16'h9ABC, 16'hDEF0, HK_NONE);
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, 16'h9ABC, 16'hDEF0}) begin
            errors++;
            $display("FAIL overrun_second: outputs=%h, required %h", obs,
                     {1'b1, 1'b1, 1'b0, 16'h9ABC, 16'hDEF0});
        end
    endtask

    task automatic test_ack_collision();
        logic [DB-1:0] l2, r2;
        l2 = DB'($urandom);
        r2 = DB'($urandom);
        do_reset(1'b1);
        lead_in();
        send_frame(DB'($urandom), DB'($urandom), HK_NONE);
        send_frame(l2, r2, HK_ACK);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, l2, r2}) begin
            errors++;
            $display("FAIL ack_collision: outputs=%h, required %h", obs, {1'b1, 1'b0, 1'b0, l2, r2});
        end
        pulse_ack();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, l2, r2}) begin
            errors++;
            $display("FAIL ack_clear: outputs=%h, required %h", obs, {1'b0, 1'b0, 1'b0, l2, r2});
        end
    endtask

    task automatic test_short_half();
        logic [DB-1:0] w;
        do_reset(1'b1);
        lead_in();
        w = DB'($urandom);
        send_half(1'b1, w, 8, -1, HK_NONE);
        model_half(1'b1, w, 8, 1'b1, 1'b0);
        w = DB'($urandom);
        send_half(1'b0, w, HALF, -1, HK_NONE);
        model_half(1'b0, w, HALF, 1'b1, 1'b0);
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL short_half_err: outputs=%h, required %h", obs,
                     {1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000});
        end
        send_frame(16'h0F0F, 16'hF0F0, HK_NONE);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b1, 16'h0F0F, 16'hF0F0}) begin
            errors++;
            $display("FAIL short_half_recover: outputs=%h, required %h", obs,
                     {1'b1, 1'b0, 1'b1, 16'h0F0F, 16'hF0F0});
        end
    endtask

    task automatic test_midstream_start();
        logic [DB-1:0] w, l3, r3;
        l3 = DB'($urandom);
        r3 = DB'($urandom);
        do_reset(1'b0);
        lead_in();
        w = DB'($urandom);
        send_half(1'b1, w, HALF, 5, HK_ENABLE);
        model_half(1'b1, w, HALF, 1'b0, 1'b0);
        w = DB'($urandom);
        send_half(1'b0, w, HALF, -1, HK_NONE);
        model_half(1'b0, w, HALF, 1'b1, 1'b0);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL midstream_discard: outputs=%h, required 0", obs);
        end
        send_frame(l3, r3, HK_NONE);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, l3, r3}) begin
            errors++;
            $display("FAIL midstream_first: outputs=%h, required %h", obs, {1'b1, 1'b0, 1'b0, l3, r3});
        end
    endtask

    task automatic test_reset_midword();
        logic [DB-1:0] l5, r5;
        l5 = DB'($urandom);
        r5 = DB'($urandom);
        do_reset(1'b1);
        lead_in();
        send_frame(DB'($urandom) | 16'h0001, DB'($urandom), HK_NONE);
        checks++;
        if (obs !== model_vec()) begin
            errors++;
            $display("FAIL reset_midword_pre: outputs=%h, required %h", obs, model_vec());
        end
        send_half(1'b1, DB'($urandom), HALF, -1, HK_NONE);
        send_half(1'b0, DB'($urandom), HALF, 9, HK_RESET);
        model_reset();
        send_frame(l5, r5, HK_NONE);
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, l5, r5}) begin
            errors++;
            $display("FAIL reset_midword_after: outputs=%h, required %h", obs, {1'b1, 1'b0, 1'b0, l5, r5});
        end
    endtask

    // Random words, random half lengths around the minimum complete length, and random acks.
    task automatic test_random_frames();
        do_reset(1'b1);
        lead_in();
        for (int i = 0; i < 10; i++) begin
            logic [DB-1:0] lw, rw;
            int nl, nr, pick;
            lw   = DB'($urandom);
            rw   = DB'($urandom);
            pick = $urandom_range(0, 7);
            nl   = (pick == 0) ? LB + DB - 1 : (pick == 1) ? LB + DB : HALF;
            pick = $urandom_range(0, 7);
            nr   = (pick == 0) ? LB + DB - 1 : (pick == 1) ? LB + DB : HALF;
            send_half(1'b1, lw, nl, -1, HK_NONE);
            model_half(1'b1, lw, nl, 1'b1, 1'b0);
            send_half(1'b0, rw, nr, -1, HK_NONE);
            model_half(1'b0, rw, nr, 1'b1, 1'b0);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("FAIL random_frame_%0d: outputs=%h, required %h", i, obs, model_vec());
            end
            if ($urandom_range(0, 2) == 0) pulse_ack();
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        ack    = 1'b0;
        bclk   = 1'b0;
        lrck   = 1'b0;
        dat    = 1'b0;
        model_reset();
        test_reset();
        test_basic_frame();
        test_overrun();
        test_ack_collision();
        test_short_half();
        test_midstream_start();
        test_reset_midword();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
